hazard_tracker: RTL and testbench

Decode-side hazard and destination-tracking block for the 5-stage pipeline. Registers destination-register information for the EXE and MEM stages and drives `rd_exe`, `rd_mem`, `RegWrite_exe`, `RegWrite_mem` into the forwarding unit. Detects load-use hazards that forwarding cannot cover, stalls fetch/decode while inserting bubbles into EXE, and applies branch/jump flushes resolved in EXE. Keeps saturating stall and flush performance counters.

---
 rtl/hazard_tracker.sv | 155 +++++++++++++++
 tb/tb_hazard_tracker.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_tracker
//  Description : Decode-side hazard and destination tracking. Holds EXE/MEM
//                destination slots for forwarding, stalls on load-use
//                hazards, applies EXE-resolved flushes, counts stalls and
//                flushes with saturating counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_tracker #(
    parameter int LOAD_STALLS = 1,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_decode,
    input  logic [4:0]       rs1_decode,
    input  logic [4:0]       rs2_decode,
    input  logic             use_rs1,
    input  logic             use_rs2,
    input  logic [4:0]       rd_decode,
    input  logic             RegWrite_decode,
    input  logic             MemRead_decode,
    input  logic             flush_exe,
    output logic [4:0]       rd_exe,
    output logic [4:0]       rd_mem,
    output logic             RegWrite_exe,
    output logic             RegWrite_mem,
    output logic             stall_fetch,
    output logic             stall_decode,
    output logic             bubble_exe,
    output logic             flush_fetch,
    output logic             flush_decode,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    // Remaining extra stall cycles after the first one (at most 1 for LOAD_STALLS=3)
    localparam logic [1:0]       C_CNT_INIT = (LOAD_STALLS > 1) ? 2'(LOAD_STALLS - 2) : 2'd0;
    localparam bit               C_MULTI    = (LOAD_STALLS > 1);
    localparam logic [CNT_W-1:0] C_CNT_MAX  = '1;

    state_t     r_state;
    state_t     w_state_next;
    logic [1:0] r_cnt;
    logic [1:0] w_cnt_next;
    logic       r_memread_exe;
    logic       w_hz;
    logic       w_stall;
    logic       w_load_slot;

    // Load in EXE whose destination is read by the decode instruction
    assign w_hz = r_memread_exe & (rd_exe != 5'd0) & valid_decode &
                  ((use_rs1 & (rs1_decode == rd_exe)) |
                   (use_rs2 & (rs2_decode == rd_exe)));

    // Stall FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state logic and pipeline control outputs; a flush overrides any stall
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_stall      = 1'b0;
        if (flush_exe) begin
            w_state_next = ST_RUN;
            w_cnt_next   = 2'd0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_hz) begin
                        w_stall = 1'b1;
                        if (C_MULTI) begin
                            w_state_next = ST_STALL;
                            w_cnt_next   = C_CNT_INIT;
                        end
                    end
                end
                ST_STALL: begin
                    w_stall = 1'b1;
                    if (r_cnt == 2'd0) begin
                        w_state_next = ST_RUN;
                    end else begin
                        w_cnt_next = r_cnt - 2'd1;
                    end
                end
                default: begin
                    w_state_next = ST_RUN;
                    w_cnt_next   = 2'd0;
                end
            endcase
        end

        // Control outputs are held low while reset is asserted
        stall_fetch  = w_stall & ~rst;
        stall_decode = w_stall & ~rst;
        flush_fetch  = flush_exe & ~rst;
        flush_decode = flush_exe & ~rst;
        bubble_exe   = (w_stall | flush_exe | ~valid_decode) & ~rst;
        w_load_slot  = valid_decode & ~w_stall & ~flush_exe;
    end

    // EXE and MEM destination slots; MEM always advances, EXE takes decode or a bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_exe        <= 5'd0;
            RegWrite_exe  <= 1'b0;
            r_memread_exe <= 1'b0;
            rd_mem        <= 5'd0;
            RegWrite_mem  <= 1'b0;
        end else begin
            rd_mem       <= rd_exe;
            RegWrite_mem <= RegWrite_exe;
            if (w_load_slot) begin
                rd_exe        <= rd_decode;
                RegWrite_exe  <= RegWrite_decode;
                r_memread_exe <= MemRead_decode;
            end else begin
                rd_exe        <= 5'd0;
                RegWrite_exe  <= 1'b0;
                r_memread_exe <= 1'b0;
            end
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall_decode && (stall_count != C_CNT_MAX)) begin
                stall_count <= stall_count + CNT_W'(1);
            end
            if (flush_exe && (flush_count != C_CNT_MAX)) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_tracker
//  Description : Directed table-driven bench for hazard_tracker with a
//                single-stall instance and a three-stall narrow-counter
//                instance for multi-cycle corner cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_tracker;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
        logic       fl;
    } in_t;

    typedef struct packed {
        logic [4:0] rd_exe;
        logic       rw_exe;
        logic [4:0] rd_mem;
        logic       rw_mem;
        logic [1:0] stall;
        logic       bub;
        logic [1:0] flush;
    } out_t;

    typedef struct {
        string name;
        in_t   in;
        out_t  exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    in_t  ia, ib;
    out_t oa, ob;
    int   checks = 0;
    int   errors = 0;

    logic [4:0]  rde_a, rdm_a, rde_b, rdm_b;
    logic        rwe_a, rwm_a, sf_a, sd_a, bu_a, ff_a, fd_a;
    logic        rwe_b, rwm_b, sf_b, sd_b, bu_b, ff_b, fd_b;
    logic [15:0] scnt_a, fcnt_a;
    logic [3:0]  scnt_b, fcnt_b;

    always #5 clk = ~clk;

    hazard_tracker #(.LOAD_STALLS(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst_a), .valid_decode(ia.valid),
        .rs1_decode(ia.rs1), .rs2_decode(ia.rs2), .use_rs1(ia.u1), .use_rs2(ia.u2),
        .rd_decode(ia.rd), .RegWrite_decode(ia.rw), .MemRead_decode(ia.mr),
        .flush_exe(ia.fl), .rd_exe(rde_a), .rd_mem(rdm_a),
        .RegWrite_exe(rwe_a), .RegWrite_mem(rwm_a),
        .stall_fetch(sf_a), .stall_decode(sd_a), .bubble_exe(bu_a),
        .flush_fetch(ff_a), .flush_decode(fd_a),
        .stall_count(scnt_a), .flush_count(fcnt_a)
    );

    hazard_tracker #(.LOAD_STALLS(3), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst_b), .valid_decode(ib.valid),
        .rs1_decode(ib.rs1), .rs2_decode(ib.rs2), .use_rs1(ib.u1), .use_rs2(ib.u2),
        .rd_decode(ib.rd), .RegWrite_decode(ib.rw), .MemRead_decode(ib.mr),
        .flush_exe(ib.fl), .rd_exe(rde_b), .rd_mem(rdm_b),
        .RegWrite_exe(rwe_b), .RegWrite_mem(rwm_b),
        .stall_fetch(sf_b), .stall_decode(sd_b), .bubble_exe(bu_b),
        .flush_fetch(ff_b), .flush_decode(fd_b),
        .stall_count(scnt_b), .flush_count(fcnt_b)
    );

    assign oa = {rde_a, rwe_a, rdm_a, rwm_a, {sf_a, sd_a}, bu_a, {ff_a, fd_a}};
    assign ob = {rde_b, rwe_b, rdm_b, rwm_b, {sf_b, sd_b}, bu_b, {ff_b, fd_b}};

    function automatic in_t mk(input logic v, input logic [4:0] r1, input logic u1,
                               input logic [4:0] r2, input logic u2, input logic [4:0] rd,
                               input logic rw, input logic mr, input logic fl);
        return {v, r1, r2, u1, u2, rd, rw, mr, fl};
    endfunction

    function automatic out_t ex(input logic [4:0] re, input logic we, input logic [4:0] rm,
                                input logic wm, input logic st, input logic bu, input logic fl);
        return {re, we, rm, wm, {2{st}}, bu, {2{fl}}};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    vec_t vecs[13];
    in_t  nop, lw5, add6, idle;
    int   n;

    initial begin
        nop  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        lw5  = mk(1, 2, 1, 0, 0, 5, 1, 1, 0);
        add6 = mk(1, 5, 1, 1, 1, 6, 1, 0, 0);

        vecs[0]  = '{"issue_rd5",     mk(1, 0, 0, 0, 0, 5, 1, 0, 0), ex(0, 0, 0, 0, 0, 0, 0)};
        vecs[1]  = '{"rd5_in_exe",    nop,                           ex(5, 1, 0, 0, 0, 0, 0)};
        vecs[2]  = '{"rd5_in_mem",    idle,                          ex(0, 0, 5, 1, 0, 1, 0)};
        vecs[3]  = '{"load_x5",       lw5,                           ex(0, 0, 0, 0, 0, 0, 0)};
        vecs[4]  = '{"load_use",      add6,                          ex(5, 1, 0, 0, 1, 1, 0)};
        vecs[5]  = '{"held_consumer", add6,                          ex(0, 0, 5, 1, 0, 0, 0)};
        vecs[6]  = '{"consumer_exe",  idle,                          ex(6, 1, 0, 0, 0, 1, 0)};
        vecs[7]  = '{"load_x5_again", lw5,                           ex(0, 0, 6, 1, 0, 0, 0)};
        vecs[8]  = '{"reads_x7_only", mk(1, 7, 1, 5, 0, 8, 1, 0, 0), ex(5, 1, 0, 0, 0, 0, 0)};
        vecs[9]  = '{"load_x0",       mk(1, 2, 1, 0, 0, 0, 1, 1, 0), ex(8, 1, 5, 1, 0, 0, 0)};
        vecs[10] = '{"reads_x0",      mk(1, 0, 1, 0, 0, 9, 1, 0, 0), ex(0, 1, 8, 1, 0, 0, 0)};
        vecs[11] = '{"flush",         mk(1, 0, 0, 0, 0, 10, 1, 0, 1), ex(9, 1, 0, 1, 0, 1, 1)};
        vecs[12] = '{"after_flush",   idle,                          ex(0, 0, 9, 1, 0, 1, 0)};

        // Reset both instances for 3 cycles
        rst_a = 1'b1;
        rst_b = 1'b1;
        ia    = nop;
        ib    = nop;
        repeat (3) @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        #1;
        chk("reset_outs_a", oa, '0);
        chk("reset_outs_b", ob, '0);
        chk("reset_cnts_a", {scnt_a, fcnt_a}, '0);
        chk("reset_cnts_b", {scnt_b, fcnt_b}, '0);

        // Table-driven vectors on the single-stall instance
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            ia = vecs[i].in;
            #1;
            chk(vecs[i].name, oa, vecs[i].exp);
        end
        @(negedge clk);
        ia = nop;
        #1;
        chk("a_stall_count", scnt_a, 16'd1);
        chk("a_flush_count", fcnt_a, 16'd1);

        // Three-stall load-use: count stall cycles with a bound
        @(negedge clk);
        ib = lw5;
        #1;
        chk("b_load_nostall", sd_b, 1'b0);
        @(negedge clk);
        ib = add6;
        n  = 0;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (!sd_b) break;
            if (!(sf_b && bu_b)) chk("b_stall_ctrl", {sf_b, bu_b}, 2'b11);
            n++;
            @(negedge clk);
        end
        chk("b_stall_cycles", n, 3);
        @(negedge clk);
        ib = nop;
        #1;
        chk("b_consumer_exe", {rde_b, rwe_b}, {5'd6, 1'b1});
        chk("b_stall_count", scnt_b, 4'd3);

        // Flush during the second stall cycle
        @(negedge clk);
        ib = lw5;
        @(negedge clk);
        ib = add6;
        #1;
        chk("b_fl_first_stall", sd_b, 1'b1);
        @(negedge clk);
        ib = mk(1, 5, 1, 1, 1, 6, 1, 0, 1);
        #1;
        chk("b_fl_stall_off", {sf_b, sd_b}, 2'b00);
        chk("b_fl_ctrl", {ff_b, fd_b, bu_b}, 3'b111);
        @(negedge clk);
        ib = add6;
        #1;
        chk("b_fl_no_residual", sd_b, 1'b0);
        chk("b_flush_count", fcnt_b, 4'd1);

        // Reset while in STALL with one extra cycle pending
        @(negedge clk);
        ib = lw5;
        @(negedge clk);
        ib = add6;
        #1;
        chk("b_rst_pre_stall", sd_b, 1'b1);
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        ib    = add6;
        #1;
        chk("b_rst_outs", ob, '0);
        chk("b_rst_cnts", {scnt_b, fcnt_b}, '0);

        // Hold flush for 2^CNT_W+5 cycles: counter must saturate, not wrap
        for (int k = 0; k < 21; k++) begin
            @(negedge clk);
            ib = mk(1, 0, 0, 0, 0, 0, 0, 0, 1);
            #1;
            if (k == 10) chk("b_flush_mid", fcnt_b, 4'd10);
        end
        @(negedge clk);
        ib = nop;
        #1;
        chk("b_flush_sat", fcnt_b, 4'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
